// File: rtl/multicycle_controller_if.sv
// Memory-side handshake between the multicycle controller and instruction/data memory.
// Handshake: mem_req (with mem_write/adr_src) is held until the cycle in which
// mem_ready is 1; that cycle completes the transfer. mem_ready outside a request is ignored.
interface multicycle_controller_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32-subset datapath, with a memory wait
// timeout and a sticky trap on illegal opcodes, illegal branch funct3 or timeouts.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             op,
  input  logic [2:0]             funct3,
  input  logic                   zero,
  multicycle_controller_if.master mem,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   reg_write,
  output logic [2:0]             imm_src,
  output logic [1:0]             alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [1:0]             result_src,
  output logic                   trap,
  output logic [3:0]             dbg_state
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11,
    TRAP     = 4'd12
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       fetch;
    logic       branch;
    logic       pc_write;
    logic       reg_write;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       trap;
  } ctrl_t;

  // Per-state control word; fetch/branch mark the strobes that are finished
  // combinationally from mem_ready or the branch condition.
  function automatic ctrl_t decode(input state_t s, input logic [6:0] opc);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req    = 1'b1;
        c.fetch      = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        c.imm_src   = 3'b010;
      end
      MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.imm_src   = (opc == OP_STORE) ? 3'b001 : 3'b000;
      end
      MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      ALUWB: c.reg_write = 1'b1;
      BRANCH: begin
        c.branch    = 1'b1;
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
      end
      JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_write  = 1'b1;
        c.imm_src   = 3'b011;
      end
      LUI: begin
        c.imm_src    = 3'b100;
        c.result_src = 2'b11;
        c.reg_write  = 1'b1;
      end
      TRAP:    c.trap = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t           state;
  state_t           state_nxt;
  ctrl_t            ctrl_q;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             timeout;
  logic             br_taken;

  assign waiting  = ((state == FETCH) || (state == MEMREAD) || (state == MEMWRITE)) && !mem.mem_ready;
  assign timeout  = waiting && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign br_taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (mem.mem_ready)  state_nxt = DECODE;
        else if (timeout)   state_nxt = TRAP;
      end
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_nxt = MEMADR;
          OP_RTYPE:          state_nxt = EXECR;
          OP_ITYPE:          state_nxt = EXECI;
          OP_BRANCH:         state_nxt = BRANCH;
          OP_JAL:            state_nxt = JAL;
          OP_LUI:            state_nxt = LUI;
          default:           state_nxt = TRAP;
        endcase
      end
      MEMADR: state_nxt = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD: begin
        if (mem.mem_ready)  state_nxt = MEMWB;
        else if (timeout)   state_nxt = TRAP;
      end
      MEMWB: state_nxt = FETCH;
      MEMWRITE: begin
        if (mem.mem_ready)  state_nxt = FETCH;
        else if (timeout)   state_nxt = TRAP;
      end
      EXECR, EXECI: state_nxt = ALUWB;
      ALUWB:        state_nxt = FETCH;
      BRANCH:       state_nxt = (funct3[2:1] == 2'b00) ? FETCH : TRAP;
      JAL:          state_nxt = ALUWB;
      LUI:          state_nxt = FETCH;
      TRAP:         state_nxt = TRAP;
      default:      state_nxt = TRAP;
    endcase
  end

  // Control word is registered from the next state; its reset value is the
  // FETCH word so the first request is presented as soon as reset drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      ctrl_q   <= decode(FETCH, 7'd0);
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ctrl_q   <= decode(state_nxt, op);
      wait_cnt <= (waiting && (state_nxt == state)) ? wait_cnt + CNT_W'(1) : '0;
    end
  end

  assign ctrl = reset ? '0 : ctrl_q;

  assign mem.mem_req   = ctrl.mem_req;
  assign mem.mem_write = ctrl.mem_write;
  assign mem.adr_src   = ctrl.adr_src;
  assign ir_write      = ctrl.fetch & mem.mem_ready;
  assign pc_write      = (ctrl.fetch & mem.mem_ready) | ctrl.pc_write | (ctrl.branch & br_taken);
  assign reg_write     = ctrl.reg_write;
  assign imm_src       = ctrl.imm_src;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign result_src    = ctrl.result_src;
  assign trap          = ctrl.trap;
  assign dbg_state     = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: an instruction-level model pushes the expected
// per-cycle control word; a negedge monitor pops and compares against the DUT.
module tb_multicycle_controller;
  localparam int T = 16;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       ir_write, pc_write, reg_write, trap;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] dbg_state;

  multicycle_controller_if mif ();

  multicycle_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .zero       (zero),
    .mem        (mif),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .imm_src    (imm_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .trap       (trap),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [17:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [17:0] act;

  assign act = {mif.mem_req, mif.mem_write, mif.adr_src, ir_write, pc_write, reg_write,
                imm_src, alu_src_a, alu_src_b, alu_op, result_src, trap};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [17:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s @%0t: got %b expected %b (memreq,memwr,adr,ir,pc,reg,imm,a,b,aluop,res,trap)",
                 n, $time, act, e);
      end
    end
  end

  // reference model: expected control word from the state's listed outputs
  function automatic logic [17:0] v(input logic mreq, input logic mwr, input logic asrc,
                                    input logic irw, input logic pcw, input logic rw,
                                    input logic [2:0] imm, input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] aop, input logic [1:0] res, input logic tr);
    return {mreq, mwr, asrc, irw, pcw, rw, imm, a, b, aop, res, tr};
  endfunction

  function automatic logic [17:0] fetch_word(input logic done);
    return v(1, 0, 0, done, done, 0, 3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 0);
  endfunction

  function automatic int klass(input logic [6:0] o);
    case (o)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011: return 2;
      7'b0010011: return 3;
      7'b1100011: return 4;
      7'b1101111: return 5;
      7'b0110111: return 6;
      default:    return 7;
    endcase
  endfunction

  // driver
  task automatic cycle(input logic mr, input logic rs, input logic [17:0] e, input string nm);
    mif.mem_ready = mr;
    reset         = rs;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'($urandom_range(0, 1)), 1'b1, 18'd0, "reset");
    cycle(1'($urandom_range(0, 1)), 1'b1, 18'd0, "reset");
  endtask

  task automatic trap_and_reset();
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++)
      cycle(1'($urandom_range(0, 1)), 1'b0, v(0,0,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,1), "trap");
    do_reset();
  endtask

  // A request waits nwait cycles; T waiting cycles without mem_ready traps.
  task automatic mem_phase(input int nwait, input logic [17:0] wait_e, input logic [17:0] done_e,
                           input string nm, output logic trapped);
    int n;
    trapped = (nwait >= T);
    n = trapped ? T : nwait;
    for (int w = 0; w < n; w++) cycle(1'b0, 1'b0, wait_e, nm);
    if (!trapped) cycle(1'b1, 1'b0, done_e, nm);
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic z,
                           input int fw, input int mw);
    logic tr;
    logic taken;
    op     = opc;
    funct3 = f3;
    zero   = 1'($urandom_range(0, 1));
    mem_phase(fw, fetch_word(0), fetch_word(1), "fetch", tr);
    if (tr) begin trap_and_reset(); return; end
    cycle(1'($urandom_range(0, 1)), 1'b0, v(0,0,0,0,0,0,3'b010,2'b01,2'b01,2'b00,2'b00,0), "decode");
    case (klass(opc))
      0, 1: begin
        cycle(1'($urandom_range(0, 1)), 1'b0,
              v(0,0,0,0,0,0, (klass(opc) == 1) ? 3'b001 : 3'b000, 2'b10,2'b01,2'b00,2'b00,0), "memadr");
        if (klass(opc) == 0) begin
          mem_phase(mw, v(1,0,1,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,0),
                        v(1,0,1,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,0), "memread", tr);
          if (tr) begin trap_and_reset(); return; end
          cycle(1'($urandom_range(0, 1)), 1'b0, v(0,0,0,0,0,1,3'b000,2'b00,2'b00,2'b00,2'b01,0), "memwb");
        end else begin
          mem_phase(mw, v(1,1,1,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,0),
                        v(1,1,1,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,0), "memwrite", tr);
          if (tr) begin trap_and_reset(); return; end
        end
      end
      2, 3: begin
        if (klass(opc) == 2)
          cycle(1'($urandom_range(0, 1)), 1'b0, v(0,0,0,0,0,0,3'b000,2'b10,2'b00,2'b10,2'b00,0), "execr");
        else
          cycle(1'($urandom_range(0, 1)), 1'b0, v(0,0,0,0,0,0,3'b000,2'b10,2'b01,2'b10,2'b00,0), "execi");
        cycle(1'($urandom_range(0, 1)), 1'b0, v(0,0,0,0,0,1,3'b000,2'b00,2'b00,2'b00,2'b00,0), "aluwb");
      end
      4: begin
        zero  = z;
        taken = ((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z);
        cycle(1'($urandom_range(0, 1)), 1'b0, v(0,0,0,0,taken,0,3'b000,2'b10,2'b00,2'b01,2'b00,0), "branch");
        if (f3 > 3'd1) trap_and_reset();
      end
      5: begin
        cycle(1'($urandom_range(0, 1)), 1'b0, v(0,0,0,0,1,0,3'b011,2'b01,2'b10,2'b00,2'b00,0), "jal");
        cycle(1'($urandom_range(0, 1)), 1'b0, v(0,0,0,0,0,1,3'b000,2'b00,2'b00,2'b00,2'b00,0), "jal_aluwb");
      end
      6: cycle(1'($urandom_range(0, 1)), 1'b0, v(0,0,0,0,0,1,3'b100,2'b00,2'b00,2'b00,2'b11,0), "lui");
      default: trap_and_reset();
    endcase
  endtask

  logic [6:0] legal_ops [7];
  logic [6:0] bad_ops   [4];

  initial begin
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0110111};
    bad_ops   = '{7'b1111111, 7'b0000000, 7'b0010111, 7'b1100111};
    reset = 1'b1;
    mif.mem_ready = 1'b0;
    op = 7'd0;
    funct3 = 3'd0;
    zero = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    run_instr(7'b0110011, 3'd0, 1'b0, 0, 0);   // add, always ready
    run_instr(7'b0000011, 3'd2, 1'b0, 3, 3);   // lw, delayed fetch and read
    run_instr(7'b1100011, 3'd1, 1'b0, 0, 0);   // bne taken
    run_instr(7'b1100011, 3'd1, 1'b1, 0, 0);   // bne not taken
    run_instr(7'b1100011, 3'd0, 1'b1, 1, 0);   // beq taken
    run_instr(7'b1100011, 3'd0, 1'b0, 0, 0);   // beq not taken
    run_instr(7'b0100011, 3'd2, 1'b0, 0, T-1); // sw, ready on last allowed cycle
    run_instr(7'b0100011, 3'd2, 1'b0, 0, 20);  // sw timeout
    run_instr(7'b0110011, 3'd0, 1'b0, 0, 0);
    run_instr(7'b1111111, 3'd0, 1'b0, 0, 0);   // illegal opcode
    run_instr(7'b1101111, 3'd0, 1'b0, 2, 0);   // jal
    run_instr(7'b0110111, 3'd0, 1'b0, 0, 0);   // lui
    run_instr(7'b0010011, 3'd0, 1'b0, 0, 0);   // addi
    run_instr(7'b1100011, 3'd2, 1'b0, 0, 0);   // branch, illegal funct3
    run_instr(7'b0110011, 3'd0, 1'b0, T, 0);   // fetch timeout
    run_instr(7'b0110011, 3'd0, 1'b0, T-1, 0);

    // reset during MEMWRITE together with mem_ready: no write may issue
    op = 7'b0100011;
    cycle(1'b1, 1'b0, fetch_word(1), "fetch");
    cycle(1'b0, 1'b0, v(0,0,0,0,0,0,3'b010,2'b01,2'b01,2'b00,2'b00,0), "decode");
    cycle(1'b0, 1'b0, v(0,0,0,0,0,0,3'b001,2'b10,2'b01,2'b00,2'b00,0), "memadr");
    cycle(1'b1, 1'b1, 18'd0, "abort_memwrite");
    cycle(1'b1, 1'b1, 18'd0, "reset");
    run_instr(7'b0110011, 3'd0, 1'b0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      logic [6:0] o;
      logic [2:0] f;
      int fw, mw;
      if ($urandom_range(0, 7) == 0) o = bad_ops[$urandom_range(0, 3)];
      else                           o = legal_ops[$urandom_range(0, 6)];
      f  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      fw = ($urandom_range(0, 11) == 0) ? T : $urandom_range(0, 3);
      mw = ($urandom_range(0, 11) == 0) ? $urandom_range(T-1, T+2) : $urandom_range(0, 3);
      run_instr(o, f, 1'($urandom_range(0, 1)), fw, mw);
    end

    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
